// File: rtl/sprite_pkg.sv
// Shared types, keycodes, screen defaults and the pixel-span helper for the
// multi-sprite engine.
package sprite_pkg;

  typedef logic [9:0]         coord_t;
  typedef logic signed [9:0]  vel_t;
  typedef logic signed [10:0] span_t;

  localparam logic [7:0] KEY_W = 8'h1A;
  localparam logic [7:0] KEY_S = 8'h16;
  localparam logic [7:0] KEY_A = 8'h04;
  localparam logic [7:0] KEY_D = 8'h07;

  localparam int DEF_X_MIN = 0;
  localparam int DEF_X_MAX = 639;
  localparam int DEF_Y_MIN = 0;
  localparam int DEF_Y_MAX = 479;

  typedef enum logic [1:0] {IDLE, UPDATE, DONE} state_t;

  typedef struct packed {
    coord_t x;
    coord_t y;
    vel_t   vx;
    vel_t   vy;
  } sprite_t;

  // True when pix lies within +/-half of centre; the 11-bit signed difference
  // keeps pixels near column 0 from wrapping into a false hit.
  function automatic logic in_span(coord_t pix, coord_t centre, span_t half);
    span_t diff;
    diff = span_t'({1'b0, pix}) - span_t'({1'b0, centre});
    return (diff <= half) && (diff >= -half);
  endfunction

endpackage

// File: rtl/sprite_step.sv
// One frame of motion for a single sprite: edge bounce per axis, optional
// keyboard steering, then position advance by the new velocity.
module sprite_step
  import sprite_pkg::*;
#(
  parameter int SIZE  = 4,
  parameter int STEP  = 1,
  parameter int X_MIN = DEF_X_MIN,
  parameter int X_MAX = DEF_X_MAX,
  parameter int Y_MIN = DEF_Y_MIN,
  parameter int Y_MAX = DEF_Y_MAX
) (
  input  logic [9:0]        x,
  input  logic [9:0]        y,
  input  logic signed [9:0] vx,
  input  logic signed [9:0] vy,
  input  logic [7:0]        keycode,
  input  logic              steer_en,
  output logic [9:0]        next_x,
  output logic [9:0]        next_y,
  output logic signed [9:0] next_vx,
  output logic signed [9:0] next_vy
);

  localparam coord_t X_HI   = coord_t'(X_MAX - SIZE);
  localparam coord_t X_LO   = coord_t'(X_MIN + SIZE);
  localparam coord_t Y_HI   = coord_t'(Y_MAX - SIZE);
  localparam coord_t Y_LO   = coord_t'(Y_MIN + SIZE);
  localparam vel_t   V_POS  = vel_t'(STEP);
  localparam vel_t   V_NEG  = vel_t'(-STEP);
  localparam vel_t   V_ZERO = '0;

  logic x_hi, x_lo, y_hi, y_lo;

  assign x_hi = (x >= X_HI);
  assign x_lo = (x <= X_LO);
  assign y_hi = (y >= Y_HI);
  assign y_lo = (y <= Y_LO);

  always_comb begin
    // NOTE: every output is given a default before any branch so no latch is inferred.
    next_vx = vx;
    next_vy = vy;

    // Steering only applies while the sprite is clear of every bound.
    if (steer_en && !(x_hi || x_lo) && !(y_hi || y_lo)) begin
      case (keycode)
        KEY_W:   begin next_vx = V_ZERO; next_vy = V_NEG;  end
        KEY_S:   begin next_vx = V_ZERO; next_vy = V_POS;  end
        KEY_A:   begin next_vx = V_NEG;  next_vy = V_ZERO; end
        KEY_D:   begin next_vx = V_POS;  next_vy = V_ZERO; end
        default: ;
      endcase
    end

    if (y_hi)      next_vy = V_NEG;
    else if (y_lo) next_vy = V_POS;

    if (x_hi)      next_vx = V_NEG;
    else if (x_lo) next_vx = V_POS;

    next_x = x + coord_t'(next_vx);
    next_y = y + coord_t'(next_vy);
  end

endmodule

// File: rtl/multi_sprite_engine.sv
// N bouncing square sprites updated one per clock after each frame strobe,
// with sprite 0 steerable and a registered pixel hit-test for the colour mapper.
module multi_sprite_engine
  import sprite_pkg::*;
#(
  parameter int N_SPRITES = 4,
  parameter int SIZE      = 4,
  parameter int STEP      = 1,
  parameter int X_MIN     = DEF_X_MIN,
  parameter int X_MAX     = DEF_X_MAX,
  parameter int Y_MIN     = DEF_Y_MIN,
  parameter int Y_MAX     = DEF_Y_MAX,
  parameter int X_START   = 64,
  parameter int X_SPACING = 128,
  parameter int Y_START   = 240
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       frame_clk,
  input  logic [7:0] keycode,
  input  logic [9:0] vga_x,
  input  logic [9:0] vga_y,
  output logic       is_sprite,
  output logic [3:0] sprite_idx,
  output logic       busy,
  output logic       update_done
);

  localparam span_t      HALF     = span_t'(SIZE);
  localparam logic [3:0] LAST_IDX = 4'(N_SPRITES - 1);

  function automatic sprite_t reset_sprite(int i);
    sprite_t s;
    s.x  = coord_t'(X_START + i * X_SPACING);
    s.y  = coord_t'(Y_START);
    s.vx = (i % 2 == 0) ? vel_t'(STEP) : vel_t'(-STEP);
    s.vy = vel_t'(STEP);
    return s;
  endfunction

  sprite_t    sprites [N_SPRITES];
  sprite_t    cur;
  sprite_t    nxt;
  state_t     state;
  logic [3:0] idx;
  logic       pending;
  logic       f1, f2, f3;
  logic       tick;
  logic       steer_en;
  coord_t     step_x, step_y;
  vel_t       step_vx, step_vy;
  logic       hit;
  logic [3:0] hit_idx;

  always_ff @(posedge clk) begin
    // NOTE: registers use non-blocking assignments so every flop samples pre-edge values.
    if (reset) begin
      f1 <= 1'b0;
      f2 <= 1'b0;
      f3 <= 1'b0;
    end else begin
      f1 <= frame_clk;
      f2 <= f1;
      f3 <= f2;
    end
  end

  assign tick = f2 & ~f3;

  always_comb begin
    cur = sprites[0];
    for (int i = 1; i < N_SPRITES; i++) begin
      if (idx == 4'(i)) cur = sprites[i];
    end
  end

  assign steer_en = (idx == 4'd0);

  sprite_step #(
    .SIZE  (SIZE),
    .STEP  (STEP),
    .X_MIN (X_MIN),
    .X_MAX (X_MAX),
    .Y_MIN (Y_MIN),
    .Y_MAX (Y_MAX)
  ) u_step (
    .x        (cur.x),
    .y        (cur.y),
    .vx       (cur.vx),
    .vy       (cur.vy),
    .keycode  (keycode),
    .steer_en (steer_en),
    .next_x   (step_x),
    .next_y   (step_y),
    .next_vx  (step_vx),
    .next_vy  (step_vy)
  );

  assign nxt = '{x: step_x, y: step_y, vx: step_vx, vy: step_vy};

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      idx         <= '0;
      pending     <= 1'b0;
      busy        <= 1'b0;
      update_done <= 1'b0;
      // NOTE: the sprite table is reset as a whole because every entry has a defined start state.
      for (int i = 0; i < N_SPRITES; i++) sprites[i] <= reset_sprite(i);
    end else begin
      update_done <= 1'b0;
      case (state)
        IDLE: begin
          if (tick || pending) begin
            state   <= UPDATE;
            idx     <= '0;
            pending <= 1'b0;
            busy    <= 1'b1;
          end
        end
        UPDATE: begin
          for (int i = 0; i < N_SPRITES; i++) begin
            if (idx == 4'(i)) sprites[i] <= nxt;
          end
          // A tick during a pass buys exactly one more pass.
          if (tick) pending <= 1'b1;
          if (idx == LAST_IDX) begin
            state       <= DONE;
            update_done <= 1'b1;
          end else begin
            idx <= idx + 4'd1;
          end
        end
        DONE: begin
          state <= IDLE;
          busy  <= 1'b0;
          if (tick) pending <= 1'b1;
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

  // Scan from the top index down so the lowest-index sprite wins.
  always_comb begin
    hit     = 1'b0;
    hit_idx = '0;
    for (int i = N_SPRITES - 1; i >= 0; i--) begin
      if (in_span(vga_x, sprites[i].x, HALF) && in_span(vga_y, sprites[i].y, HALF)) begin
        hit     = 1'b1;
        hit_idx = 4'(i);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      is_sprite  <= 1'b0;
      sprite_idx <= '0;
    end else begin
      is_sprite  <= hit;
      sprite_idx <= hit_idx;
    end
  end

endmodule

// File: tb/tb_multi_sprite_engine.sv
// Self-checking bench for multi_sprite_engine: reset table, frame timing,
// bounce and steering, pending tick, overlap priority and mid-pass reset.
module tb_multi_sprite_engine;

  localparam int N    = 4;
  localparam int SIZE = 4;
  localparam int X_LO = SIZE;
  localparam int X_HI = 639 - SIZE;
  localparam int Y_LO = SIZE;
  localparam int Y_HI = 479 - SIZE;
  localparam logic [7:0] K_W = 8'h1A;
  localparam logic [7:0] K_S = 8'h16;
  localparam logic [7:0] K_A = 8'h04;
  localparam logic [7:0] K_D = 8'h07;

  logic       clk;
  logic       reset;
  logic       frame_clk;
  logic [7:0] keycode;
  logic [9:0] vga_x;
  logic [9:0] vga_y;
  logic       is_sprite;
  logic [3:0] sprite_idx;
  logic       busy;
  logic       update_done;

  multi_sprite_engine dut (
    .clk         (clk),
    .reset       (reset),
    .frame_clk   (frame_clk),
    .keycode     (keycode),
    .vga_x       (vga_x),
    .vga_y       (vga_y),
    .is_sprite   (is_sprite),
    .sprite_idx  (sprite_idx),
    .busy        (busy),
    .update_done (update_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string      name;
    logic       hit;
    logic [3:0] idx;
  } exp_t;

  typedef struct {
    int         px;
    int         py;
    logic       hit;
    logic [3:0] idx;
  } vec_t;

  exp_t sb[$];
  vec_t vecs[15];

  int mx[N], my[N], mvx[N], mvy[N];
  int n_pass   = 0;
  int n_checks = 0;

  task automatic check(string name, logic [31:0] got, logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d", name, got, exp);
  endtask

  function automatic void model_reset();
    for (int i = 0; i < N; i++) begin
      mx[i]  = 64 + 128 * i;
      my[i]  = 240;
      mvx[i] = (i % 2 == 0) ? 1 : -1;
      mvy[i] = 1;
    end
  endfunction

  function automatic void model_frame(logic [7:0] key);
    for (int i = 0; i < N; i++) begin
      int x, y, vx, vy;
      logic xb, yb;
      x = mx[i]; y = my[i]; vx = mvx[i]; vy = mvy[i];
      xb = (x >= X_HI) || (x <= X_LO);
      yb = (y >= Y_HI) || (y <= Y_LO);
      if (i == 0 && !xb && !yb) begin
        if (key == K_W)      begin vx = 0;  vy = -1; end
        else if (key == K_S) begin vx = 0;  vy = 1;  end
        else if (key == K_A) begin vx = -1; vy = 0;  end
        else if (key == K_D) begin vx = 1;  vy = 0;  end
      end
      if (y >= Y_HI) vy = -1;
      else if (y <= Y_LO) vy = 1;
      if (x >= X_HI) vx = -1;
      else if (x <= X_LO) vx = 1;
      mvx[i] = vx; mvy[i] = vy;
      mx[i] = (x + vx) & 1023;
      my[i] = (y + vy) & 1023;
    end
  endfunction

  function automatic void model_hit(int px, int py, output logic h, output logic [3:0] id);
    h = 1'b0; id = 4'd0;
    for (int i = 0; i < N; i++) begin
      int dx, dy;
      dx = px - mx[i];
      dy = py - my[i];
      if (!h && dx >= -SIZE && dx <= SIZE && dy >= -SIZE && dy <= SIZE) begin
        h = 1'b1; id = 4'(i);
      end
    end
  endfunction

  task automatic probe_exp(string name, int px, int py, logic eh, logic [3:0] ei);
    exp_t e;
    @(negedge clk);
    vga_x = 10'(px);
    vga_y = 10'(py);
    e.name = name; e.hit = eh; e.idx = ei;
    sb.push_back(e);
    @(posedge clk); #1;
    e = sb.pop_front();
    check({e.name, "_hit"}, is_sprite, e.hit);
    check({e.name, "_idx"}, sprite_idx, e.idx);
  endtask

  task automatic probe(string name, int px, int py);
    logic h;
    logic [3:0] id;
    model_hit(px & 1023, py & 1023, h, id);
    probe_exp(name, px & 1023, py & 1023, h, id);
  endtask

  // Centre, corner and just-outside pixels pin the sprite's position exactly.
  task automatic probe_sprite(string name, int i);
    probe(name, mx[i], my[i]);
    probe(name, mx[i] + SIZE, my[i] - SIZE);
    probe(name, mx[i] + SIZE + 1, my[i]);
    probe(name, mx[i] - SIZE - 1, my[i]);
    probe(name, mx[i], my[i] + SIZE + 1);
    probe(name, mx[i], my[i] - SIZE - 1);
  endtask

  task automatic do_frame(logic [7:0] key);
    int seen;
    keycode = key;
    @(negedge clk) frame_clk = 1'b1;
    @(negedge clk) frame_clk = 1'b0;
    seen = 0;
    for (int c = 0; c < 20 && seen == 0; c++) begin
      @(posedge clk); #1;
      if (update_done) seen = 1;
    end
    check("frame_done", seen, 1);
    @(posedge clk); #1;
    model_frame(key);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int busy_cnt, done_cnt, done_at, last_busy, seen;

    vecs[0]  = '{0,   0,   1'b0, 4'd0};
    vecs[1]  = '{64,  240, 1'b1, 4'd0};
    vecs[2]  = '{68,  244, 1'b1, 4'd0};
    vecs[3]  = '{60,  236, 1'b1, 4'd0};
    vecs[4]  = '{69,  240, 1'b0, 4'd0};
    vecs[5]  = '{59,  240, 1'b0, 4'd0};
    vecs[6]  = '{64,  245, 1'b0, 4'd0};
    vecs[7]  = '{192, 240, 1'b1, 4'd1};
    vecs[8]  = '{188, 240, 1'b1, 4'd1};
    vecs[9]  = '{197, 240, 1'b0, 4'd0};
    vecs[10] = '{320, 244, 1'b1, 4'd2};
    vecs[11] = '{320, 235, 1'b0, 4'd0};
    vecs[12] = '{452, 236, 1'b1, 4'd3};
    vecs[13] = '{453, 240, 1'b0, 4'd0};
    vecs[14] = '{639, 479, 1'b0, 4'd0};

    reset = 1'b1; frame_clk = 1'b0; keycode = 8'h00; vga_x = '0; vga_y = '0;
    model_reset();
    repeat (5) @(posedge clk);
    #1;
    check("rst_busy", busy, 0);
    check("rst_done", update_done, 0);
    check("rst_is_sprite", is_sprite, 0);
    check("rst_sprite_idx", sprite_idx, 0);
    @(negedge clk) reset = 1'b0;

    for (int v = 0; v < 15; v++)
      probe_exp($sformatf("reset_vec%0d", v), vecs[v].px, vecs[v].py, vecs[v].hit, vecs[v].idx);

    // First frame: busy for N+1 cycles, one done pulse on the last busy cycle.
    keycode = 8'h00;
    @(negedge clk) frame_clk = 1'b1;
    @(negedge clk) frame_clk = 1'b0;
    busy_cnt = 0; done_cnt = 0; done_at = -1; last_busy = -1;
    for (int c = 0; c < 20; c++) begin
      @(posedge clk); #1;
      if (busy) begin busy_cnt++; last_busy = c; end
      if (update_done) begin done_cnt++; done_at = c; end
    end
    check("frame1_busy_cycles", busy_cnt, N + 1);
    check("frame1_done_pulses", done_cnt, 1);
    check("frame1_done_last_busy", done_at, last_busy);
    model_frame(8'h00);
    probe_exp("frame1_s0_corner", 65 + SIZE, 241 + SIZE, 1'b1, 4'd0);
    probe_exp("frame1_s0_right", 65 + SIZE + 1, 241, 1'b0, 4'd0);
    probe_exp("frame1_s1_corner", 191 - SIZE, 241 - SIZE, 1'b1, 4'd1);
    probe_exp("frame1_s1_left", 191 - SIZE - 1, 241, 1'b0, 4'd0);
    probe_sprite("frame1_s0", 0);
    probe_sprite("frame1_s1", 1);

    // Free-running bounce until sprites 0 and 2 coincide.
    for (int f = 0; f < 600 && !(mx[0] == mx[2] && my[0] == my[2]); f++) do_frame(8'h00);
    probe_exp("overlap_centre", mx[2], my[2], 1'b1, 4'd0);
    probe_exp("overlap_edge", mx[2] + SIZE, my[2] - SIZE, 1'b1, 4'd0);
    probe_sprite("overlap_s3", 3);

    for (int f = 0; f < 3; f++) begin
      do_frame(K_W);
      probe_sprite("key_w_s0", 0);
    end

    for (int f = 0; f < 300 && mx[0] != X_HI; f++) do_frame(K_D);
    probe_sprite("right_edge_s0", 0);
    probe_exp("right_edge_outside", X_HI + SIZE + 1, my[0], 1'b0, 4'd0);
    do_frame(K_D);
    probe_sprite("right_bounce_s0", 0);

    // Three rises in one pass window: the second pends, the third is dropped.
    keycode = 8'h00;
    done_cnt = 0;
    for (int c = 0; c < 36; c++) begin
      @(negedge clk) frame_clk = (c < 6) ? ((c % 2) == 0) : 1'b0;
      @(posedge clk); #1;
      if (update_done) done_cnt++;
    end
    check("pending_done_pulses", done_cnt, 2);
    model_frame(8'h00);
    model_frame(8'h00);
    probe_sprite("pending_s0", 0);
    probe_sprite("pending_s1", 1);

    // Reset while idx=2 is being processed.
    @(negedge clk) frame_clk = 1'b1;
    @(negedge clk) frame_clk = 1'b0;
    seen = 0;
    for (int c = 0; c < 20 && seen == 0; c++) begin
      @(posedge clk); #1;
      if (busy) seen = 1;
    end
    check("midrst_busy_seen", seen, 1);
    @(posedge clk);
    @(posedge clk);
    @(negedge clk) reset = 1'b1;
    @(posedge clk); #1;
    check("midrst_busy", busy, 0);
    check("midrst_done", update_done, 0);
    check("midrst_is_sprite", is_sprite, 0);
    @(negedge clk) reset = 1'b0;
    done_cnt = 0; busy_cnt = 0;
    for (int c = 0; c < 10; c++) begin
      @(posedge clk); #1;
      if (update_done) done_cnt++;
      if (busy) busy_cnt++;
    end
    check("midrst_no_done", done_cnt, 0);
    check("midrst_stays_idle", busy_cnt, 0);
    model_reset();
    probe_exp("midrst_s0_centre", 64, 240, 1'b1, 4'd0);
    probe_exp("midrst_s1_centre", 192, 240, 1'b1, 4'd1);
    for (int i = 0; i < N; i++) probe_sprite($sformatf("midrst_s%0d", i), i);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
